// File: rtl/bloqueio_pkg.sv
// -----------------------------------------------------------------------------
// bloqueio_pkg
// Shared definitions for the lockout controller of the lock datapath:
//   - estado_t: lockout state machine encoding (LIVRE / BLOQUEIO)
//   - default attempt limit and lockout duration
//   - widths of the attempt counter and the remaining-time counter
// -----------------------------------------------------------------------------
package bloqueio_pkg;

    typedef enum logic {
        LIVRE    = 1'b0,
        BLOQUEIO = 1'b1
    } estado_t;

    localparam int MAX_TENTATIVAS_PADRAO = 3;
    localparam int TEMPO_BLOQUEIO_PADRAO = 1000;

    localparam int LARGURA_TENTATIVAS = 3;
    localparam int LARGURA_TEMPO      = 16;

endpackage

// File: rtl/detector_borda.sv
// -----------------------------------------------------------------------------
// detector_borda
// Rising-edge detector: compares the input against a registered copy of itself
// taken one clock earlier.
// Ports:
//   clk_div : clock, rising edge
//   rst_n   : synchronous active-low reset (clears the delayed copy)
//   sinal   : level to watch
//   borda   : high during the cycle in which sinal is 1 and was 0 one cycle ago
// -----------------------------------------------------------------------------
module detector_borda (
    input  logic clk_div,
    input  logic rst_n,
    input  logic sinal,
    output logic borda
);

    logic sinal_q;
    logic sinal_d;

    always_comb begin
        sinal_d = sinal;
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_d;
        end
    end

    assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/controle_bloqueio.sv
// -----------------------------------------------------------------------------
// controle_bloqueio
// Sits between the enter synchronizer and the Moore lock FSM. Counts
// consecutive ERROR rising edges; after MAX_TENTATIVAS of them it locks out the
// enter request for TEMPO_BLOQUEIO cycles. An OPEN rising edge clears the count.
// Ports:
//   clk_div        : single clock, rising edge
//   rst_n          : synchronous active-low reset
//   sinc_enter     : synchronized enter request
//   ERROR          : error level from the lock FSM
//   OPEN           : open/success level from the lock FSM
//   enter_liberado : enter forwarded to the lock FSM (registered, gated by lockout)
//   BLOQUEADO      : high while lockout is active
//   tentativas     : current consecutive-error count
//   tempo_restante : remaining lockout cycles, 0 outside lockout
// -----------------------------------------------------------------------------
module controle_bloqueio
    import bloqueio_pkg::*;
#(
    parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO,
    parameter int TEMPO_BLOQUEIO = TEMPO_BLOQUEIO_PADRAO
) (
    input  logic                          clk_div,
    input  logic                          rst_n,
    input  logic                          sinc_enter,
    input  logic                          ERROR,
    input  logic                          OPEN,
    output logic                          enter_liberado,
    output logic                          BLOQUEADO,
    output logic [LARGURA_TENTATIVAS-1:0] tentativas,
    output logic [LARGURA_TEMPO-1:0]      tempo_restante
);

    localparam logic [LARGURA_TENTATIVAS-1:0] TENT_MAX     = LARGURA_TENTATIVAS'(MAX_TENTATIVAS);
    localparam logic [LARGURA_TENTATIVAS-1:0] TENT_LIMIAR  = LARGURA_TENTATIVAS'(MAX_TENTATIVAS - 1);
    localparam logic [LARGURA_TEMPO-1:0]      TEMPO_CARGA  = LARGURA_TEMPO'(TEMPO_BLOQUEIO);

    estado_t                        estado_q, estado_d;
    logic [LARGURA_TENTATIVAS-1:0]  tent_q, tent_d;
    logic [LARGURA_TEMPO-1:0]       tempo_q, tempo_d;
    logic                           enter_q, enter_d;

    logic borda_error;
    logic borda_open;
    logic inicia_bloqueio;
    logic fim_bloqueio;

    // The edge detectors keep tracking during lockout, so a level that is
    // already high when lockout ends is not seen as a new edge.
    detector_borda u_borda_error (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .sinal   (ERROR),
        .borda   (borda_error)
    );

    detector_borda u_borda_open (
        .clk_div (clk_div),
        .rst_n   (rst_n),
        .sinal   (OPEN),
        .borda   (borda_open)
    );

    // OPEN has priority over ERROR when both rise together.
    assign inicia_bloqueio = (estado_q == LIVRE) && borda_error && !borda_open
                             && (tent_q == TENT_LIMIAR);

    // "<= 1" rather than "== 1" so a zero count can never hold the lock forever.
    assign fim_bloqueio = (estado_q == BLOQUEIO) && (tempo_q <= LARGURA_TEMPO'(1));

    // State register
    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            estado_q <= LIVRE;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next-state logic
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            LIVRE:    if (inicia_bloqueio) estado_d = BLOQUEIO;
            BLOQUEIO: if (fim_bloqueio)    estado_d = LIVRE;
            default:  estado_d = LIVRE;
        endcase
    end

    // Datapath next values
    always_comb begin
        tent_d  = tent_q;
        tempo_d = tempo_q;
        enter_d = 1'b0;
        case (estado_q)
            LIVRE: begin
                tempo_d = '0;
                if (borda_open) begin
                    tent_d = '0;
                end else if (inicia_bloqueio) begin
                    tent_d  = TENT_MAX;
                    tempo_d = TEMPO_CARGA;
                end else if (borda_error && (tent_q < TENT_LIMIAR)) begin
                    tent_d = tent_q + LARGURA_TENTATIVAS'(1);
                end
                // Enter is suppressed already in the first lockout cycle.
                enter_d = inicia_bloqueio ? 1'b0 : sinc_enter;
            end
            BLOQUEIO: begin
                if (fim_bloqueio) begin
                    tempo_d = '0;
                    tent_d  = '0;
                end else begin
                    tempo_d = tempo_q - LARGURA_TEMPO'(1);
                end
            end
            default: begin
                tent_d  = '0;
                tempo_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (!rst_n) begin
            tent_q  <= '0;
            tempo_q <= '0;
            enter_q <= 1'b0;
        end else begin
            tent_q  <= tent_d;
            tempo_q <= tempo_d;
            enter_q <= enter_d;
        end
    end

    // Output logic
    always_comb begin
        BLOQUEADO      = (estado_q == BLOQUEIO);
        enter_liberado = enter_q;
        tentativas     = tent_q;
        tempo_restante = tempo_q;
    end

endmodule

// File: tb/tb_controle_bloqueio.sv
module tb_controle_bloqueio;

    logic        clk_div;
    logic        rst_n;
    logic        sinc_enter;
    logic        ERROR;
    logic        OPEN;
    logic        enter_liberado;
    logic        BLOQUEADO;
    logic [2:0]  tentativas;
    logic [15:0] tempo_restante;

    int tests_run;
    int tests_failed;

    controle_bloqueio #(
        .MAX_TENTATIVAS (3),
        .TEMPO_BLOQUEIO (8)
    ) dut (
        .clk_div        (clk_div),
        .rst_n          (rst_n),
        .sinc_enter     (sinc_enter),
        .ERROR          (ERROR),
        .OPEN           (OPEN),
        .enter_liberado (enter_liberado),
        .BLOQUEADO      (BLOQUEADO),
        .tentativas     (tentativas),
        .tempo_restante (tempo_restante)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    // Advance one clock and sample 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_en, input logic [31:0] e_bl,
                               input logic [31:0] e_tent, input logic [31:0] e_tempo);
        check({tag, ".enter"}, 32'(enter_liberado), e_en);
        check({tag, ".bloq"},  32'(BLOQUEADO),      e_bl);
        check({tag, ".tent"},  32'(tentativas),     e_tent);
        check({tag, ".tempo"}, 32'(tempo_restante), e_tempo);
    endtask

    // One ERROR pulse: high for one cycle, then low for one cycle.
    task automatic pulso_error(input string tag, input logic [31:0] e_tent);
        ERROR = 1'b1;
        tick();
        check({tag, ".tent_up"}, 32'(tentativas), e_tent);
        ERROR = 1'b0;
        tick();
        check({tag, ".tent_hold"}, 32'(tentativas), e_tent);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n      = 1'b0;
        sinc_enter = 1'b0;
        ERROR      = 1'b0;
        OPEN       = 1'b0;

        // Reset state
        tick();
        tick();
        check_state("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_state("idle", 0, 0, 0, 0);

        // Enter passthrough: one-cycle pulse, one cycle late
        sinc_enter = 1'b1;
        tick();
        check_state("pass.hi", 1, 0, 0, 0);
        sinc_enter = 1'b0;
        tick();
        check_state("pass.lo", 0, 0, 0, 0);
        tick();
        check_state("pass.lo2", 0, 0, 0, 0);

        // Error count then clear by OPEN
        pulso_error("cnt.e1", 1);
        pulso_error("cnt.e2", 2);
        OPEN = 1'b1;
        tick();
        check_state("cnt.open", 0, 0, 0, 0);
        OPEN = 1'b0;
        tick();
        check_state("cnt.after", 0, 0, 0, 0);

        // Lockout with enter blocked, countdown, exit, enter in first free cycle
        pulso_error("lk.e1", 1);
        pulso_error("lk.e2", 2);
        ERROR      = 1'b1;
        sinc_enter = 1'b1;
        tick();
        check_state("lk.start", 0, 1, 3, 8);
        ERROR = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            sinc_enter = (i % 2 == 1);
            tick();
            check_state($sformatf("lk.cd%0d", i), 0, 1, 3, i);
        end
        sinc_enter = 1'b1;
        tick();
        check_state("lk.exit", 0, 0, 0, 0);
        tick();
        check_state("lk.fwd", 1, 0, 0, 0);
        sinc_enter = 1'b0;
        tick();
        check_state("lk.fwd_lo", 0, 0, 0, 0);

        // Simultaneous ERROR and OPEN with tentativas at threshold
        pulso_error("sim.e1", 1);
        pulso_error("sim.e2", 2);
        ERROR = 1'b1;
        OPEN  = 1'b1;
        tick();
        check_state("sim.both", 0, 0, 0, 0);
        ERROR = 1'b0;
        OPEN  = 1'b0;
        tick();
        check_state("sim.after", 0, 0, 0, 0);

        // Reset in the middle of lockout
        pulso_error("rst.e1", 1);
        pulso_error("rst.e2", 2);
        ERROR = 1'b1;
        tick();
        check_state("rst.start", 0, 1, 3, 8);
        ERROR = 1'b0;
        for (int i = 7; i >= 5; i--) begin
            tick();
            check_state($sformatf("rst.cd%0d", i), 0, 1, 3, i);
        end
        rst_n = 1'b0;
        tick();
        check_state("rst.abort", 0, 0, 0, 0);
        rst_n      = 1'b1;
        sinc_enter = 1'b1;
        tick();
        check_state("rst.fwd", 1, 0, 0, 0);
        sinc_enter = 1'b0;
        tick();
        check_state("rst.fwd_lo", 0, 0, 0, 0);

        // ERROR held high across lockout exit: no new edge afterwards
        pulso_error("hold.e1", 1);
        pulso_error("hold.e2", 2);
        ERROR = 1'b1;
        tick();
        check_state("hold.start", 0, 1, 3, 8);
        for (int i = 7; i >= 1; i--) begin
            tick();
            check_state($sformatf("hold.cd%0d", i), 0, 1, 3, i);
        end
        tick();
        check_state("hold.exit", 0, 0, 0, 0);
        tick();
        check_state("hold.after1", 0, 0, 0, 0);
        tick();
        check_state("hold.after2", 0, 0, 0, 0);
        ERROR = 1'b0;
        tick();
        pulso_error("hold.fresh", 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/controle_bloqueio.md
CONTROLE_BLOQUEIO -- requirements
Module: controle_bloqueio

Interface
REQ-001 Parameter MAX_TENTATIVAS, default 3, SHALL set the number of consecutive ERROR rising edges that trigger lockout (legal range 1..7).
REQ-002 Parameter TEMPO_BLOQUEIO, default 1000, SHALL set the lockout duration in clk_div cycles (legal range 1..65535).
REQ-003 clk_div  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be a synchronous, active-low reset.
REQ-005 sinc_enter  input  1  SHALL carry the synchronized enter request from the synchronizer stage.
REQ-006 ERROR  input  1  SHALL carry the error level from fsm_moore.
REQ-007 OPEN  input  1  SHALL carry the open/success level from fsm_moore.
REQ-008 enter_liberado  output  1  SHALL be the gated enter forwarded to fsm_moore.
REQ-009 BLOQUEADO  output  1  SHALL be high while lockout is active.
REQ-010 tentativas  output  3  SHALL show the current consecutive-error count.
REQ-011 tempo_restante  output  16  SHALL show the remaining lockout cycles, or 0 outside lockout.

Function
REQ-012 The block SHALL detect ERROR and OPEN rising edges against a one-cycle-delayed registered copy of each signal.
REQ-013 The state machine SHALL have exactly these states: LIVRE and BLOQUEIO.
REQ-014 In LIVRE, enter_liberado SHALL equal sinc_enter delayed by exactly one clk_div cycle (registered).
REQ-015 In BLOQUEIO, and in the cycle BLOQUEIO is entered, enter_liberado SHALL be 0 regardless of sinc_enter.
REQ-016 In LIVRE, an OPEN rising edge SHALL clear tentativas to 0 on the next edge.
REQ-017 In LIVRE, an ERROR rising edge with tentativas < MAX_TENTATIVAS-1 SHALL increment tentativas by 1.
REQ-018 In LIVRE, an ERROR rising edge with tentativas = MAX_TENTATIVAS-1 SHALL cause all of the following on the next edge: set tentativas to MAX_TENTATIVAS, move to BLOQUEIO, set BLOQUEADO to 1, and load tempo_restante with TEMPO_BLOQUEIO.
REQ-019 When OPEN and ERROR rising edges occur in the same cycle, OPEN SHALL win: tentativas clears and no lockout starts.
REQ-020 In BLOQUEIO, tempo_restante SHALL decrement by 1 per cycle.
REQ-021 In BLOQUEIO, when tempo_restante = 1, the next edge SHALL do all of the following: move to LIVRE, clear BLOQUEADO, set tempo_restante to 0, and clear tentativas to 0.
REQ-022 In BLOQUEIO, ERROR and OPEN edges SHALL be ignored; the edge-detect registers SHALL still track their inputs, so a level already high at exit produces no edge.
REQ-023 tentativas SHALL never exceed MAX_TENTATIVAS; tempo_restante SHALL never wrap below 0.
REQ-024 A sinc_enter that is high in the first LIVRE cycle after lockout SHALL be forwarded one cycle later, per REQ-014.

Reset
REQ-025 When rst_n = 0 at a clk_div edge, the block SHALL set state to LIVRE, all outputs to 0, and the edge-detect registers to 0.
REQ-026 A reset asserted mid-lockout SHALL abort the lockout immediately at that edge, with no residual count.
REQ-027 The block SHALL have no asynchronous reset paths.

Structure
REQ-028 A shared package bloqueio_pkg SHALL hold the state enum (LIVRE, BLOQUEIO), the default constants MAX_TENTATIVAS_PADRAO = 3 and TEMPO_BLOQUEIO_PADRAO = 1000, and the widths 3 and 16.
REQ-029 One sub-module, detector_borda (clk_div, rst_n, sinal, borda), SHALL provide rising-edge detection and SHALL be instantiated twice: once for ERROR and once for OPEN.
REQ-030 The block SHALL sit between sincronizador_enter_clock and fsm_moore in the lock datapath.

Verification
Directed scenarios run with MAX_TENTATIVAS = 3 and TEMPO_BLOQUEIO = 8:
REQ-031 Enter passthrough: sinc_enter pulses for 1 cycle in LIVRE -> enter_liberado is high for exactly 1 cycle, one cycle later; tentativas stays 0.
REQ-032 Error count and reset by OPEN: 2 ERROR pulses, then 1 OPEN pulse -> tentativas reads 1, then 2, then 0; BLOQUEADO stays 0.
REQ-033 Lockout: 3 ERROR pulses -> BLOQUEADO = 1 and tempo_restante = 8 the cycle after the third edge; tempo_restante counts down 7..1; sinc_enter pulses during lockout produce no enter_liberado; after 8 cycles BLOQUEADO = 0 and tentativas = 0.
REQ-034 Simultaneous edges: with tentativas = 2, ERROR and OPEN rise in the same cycle -> tentativas = 0 and BLOQUEADO stays 0.
REQ-035 Reset mid-lockout: rst_n = 0 for 1 cycle when tempo_restante = 5 -> next cycle has BLOQUEADO = 0, tempo_restante = 0, tentativas = 0, and a sinc_enter pulse is forwarded.
REQ-036 ERROR held high across lockout exit: -> no new edge is counted; tentativas stays 0 after exit.
